// File: rtl/play_ctrl_pkg.sv
// play_ctrl_pkg: shared types and helpers for the tone-player playback sequencer.
//   state_t      : sequencer state encoding (IDLE / PLAY / PAUSE)
//   TEMPO_*      : tempo select codes driven on play_ctrl.tempo
//   tempo_period : beat length in clock cycles for a tempo code
package play_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [1:0] TEMPO_NORM = 2'b00;
  localparam logic [1:0] TEMPO_FAST = 2'b01;
  localparam logic [1:0] TEMPO_SLOW = 2'b10;

  // Code 2'b11 is unassigned and plays at normal tempo.
  function automatic int unsigned tempo_period(input logic [1:0] tempo,
                                               input int unsigned beat_cycles);
    int unsigned p;
    case (tempo)
      TEMPO_FAST: p = beat_cycles / 2;
      TEMPO_SLOW: p = beat_cycles * 2;
      default:    p = beat_cycles;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/play_ctrl_beat_timer.sv
// beat_timer: beat counter with a latched beat period.
//   clk, reset : clock and asynchronous active-low reset
//   tempo      : tempo code sampled whenever the period is (re)loaded
//   load       : start of playback; counter to 0 and period reloaded
//   clear      : counter to 0, period kept
//   run        : count this cycle; at the last cycle of the beat the
//                counter wraps to 0 and the period is reloaded
//   at_end     : counter is on the last cycle of the beat
//   in_window  : counter is before the articulation gap (sound allowed)
module beat_timer
  import play_ctrl_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES  = 250000,
  parameter int unsigned CNT_BITS    = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tempo,
  input  logic       load,
  input  logic       clear,
  input  logic       run,
  output logic       at_end,
  output logic       in_window
);

  logic [CNT_BITS-1:0] beat_cnt;
  logic [CNT_BITS-1:0] period;
  logic [CNT_BITS-1:0] next_period;

  assign next_period = CNT_BITS'(tempo_period(tempo, BEAT_CYCLES));
  assign at_end      = (beat_cnt == period - CNT_BITS'(1));

  // Compare as beat_cnt + GAP < period in a wide domain so a gap at or
  // beyond the period simply keeps the whole beat silent instead of
  // wrapping around.
  assign in_window = ((33'(beat_cnt) + 33'(GAP_CYCLES)) < 33'(period));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      period   <= CNT_BITS'(BEAT_CYCLES);
    end else if (load) begin
      beat_cnt <= '0;
      period   <= next_period;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (run) begin
      if (at_end) begin
        beat_cnt <= '0;
        period   <= next_period;
      end else begin
        beat_cnt <= beat_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/play_ctrl.sv
// play_ctrl: playback sequencer for the tone player (10 MHz domain).
//   clk_10m, reset : system clock, asynchronous active-low reset
//   btn_play/stop/next/prev : level buttons, rising-edge detected here
//   loop_en        : restart the song at its end instead of stopping
//   tempo          : 00 normal, 01 fast, 10 slow, 11 normal
//   rom_addr       : {song, note index} to the song ROM (registered)
//   mute           : speaker gate, 1 = silent (registered)
//   playing/paused : registered state decode
//   beat_tick      : one-cycle pulse as the note index advances
//   state_dbg      : live FSM state for observation
module play_ctrl
  import play_ctrl_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES  = 250000,
  parameter int unsigned SONG_BITS   = 2,
  parameter int unsigned IDX_BITS    = 6,
  parameter int unsigned CNT_BITS    = 23
) (
  input  logic                          clk_10m,
  input  logic                          reset,
  input  logic                          btn_play,
  input  logic                          btn_stop,
  input  logic                          btn_next,
  input  logic                          btn_prev,
  input  logic                          loop_en,
  input  logic [1:0]                    tempo,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  output logic                          mute,
  output logic                          playing,
  output logic                          paused,
  output logic                          beat_tick,
  output logic [1:0]                    state_dbg
);

  state_t               state, state_d;
  logic [SONG_BITS-1:0] song, song_d;
  logic [IDX_BITS-1:0]  idx, idx_d;
  logic                 play_q, stop_q, next_q, prev_q;
  logic                 e_play, e_stop, e_next, e_prev;
  logic                 t_load, t_clear, t_run;
  logic                 at_end, in_window, boundary;

  assign e_play = btn_play & ~play_q;
  assign e_stop = btn_stop & ~stop_q;
  assign e_next = btn_next & ~next_q;
  assign e_prev = btn_prev & ~prev_q;

  assign boundary  = (state == PLAY) && at_end;
  assign state_dbg = state;

  beat_timer #(
    .BEAT_CYCLES (BEAT_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .CNT_BITS    (CNT_BITS)
  ) u_timer (
    .clk       (clk_10m),
    .reset     (reset),
    .tempo     (tempo),
    .load      (t_load),
    .clear     (t_clear),
    .run       (t_run),
    .at_end    (at_end),
    .in_window (in_window)
  );

  // Only the highest-priority edge acts (stop > next > prev > play); any
  // button action takes precedence over the beat-boundary update.
  always_comb begin
    state_d = state;
    song_d  = song;
    idx_d   = idx;
    t_load  = 1'b0;
    t_clear = 1'b0;
    t_run   = 1'b0;
    if (e_stop) begin
      state_d = IDLE;
      idx_d   = '0;
      t_clear = 1'b1;
    end else if (e_next) begin
      song_d  = song + SONG_BITS'(1);
      idx_d   = '0;
      t_clear = 1'b1;
    end else if (e_prev) begin
      song_d  = song - SONG_BITS'(1);
      idx_d   = '0;
      t_clear = 1'b1;
    end else if (e_play) begin
      case (state)
        IDLE: begin
          state_d = PLAY;
          idx_d   = '0;
          t_load  = 1'b1;
        end
        PLAY:    state_d = PAUSE;
        PAUSE:   state_d = PLAY;
        default: state_d = IDLE;
      endcase
    end else if (state == PLAY) begin
      t_run = 1'b1;
      if (at_end) begin
        if (idx == {IDX_BITS{1'b1}}) begin
          idx_d = '0;
          if (!loop_en) state_d = IDLE;
        end else begin
          idx_d = idx + IDX_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_10m or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      song   <= '0;
      idx    <= '0;
      play_q <= 1'b0;
      stop_q <= 1'b0;
      next_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      state  <= state_d;
      song   <= song_d;
      idx    <= idx_d;
      play_q <= btn_play;
      stop_q <= btn_stop;
      next_q <= btn_next;
      prev_q <= btn_prev;
    end
  end

  // Outputs lag the state/index registers by one cycle.
  always_ff @(posedge clk_10m or negedge reset) begin
    if (!reset) begin
      rom_addr  <= '0;
      mute      <= 1'b1;
      playing   <= 1'b0;
      paused    <= 1'b0;
      beat_tick <= 1'b0;
    end else begin
      rom_addr  <= {song, idx};
      mute      <= !((state == PLAY) && in_window);
      playing   <= (state == PLAY);
      paused    <= (state == PAUSE);
      beat_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_play_ctrl.sv
`timescale 1ns/1ps
module tb_play_ctrl;

  localparam int BEAT  = 8;
  localparam int GAP   = 2;
  localparam int SB    = 2;
  localparam int IB    = 2;
  localparam int AW    = SB + IB;
  localparam int NSONG = 1 << SB;
  localparam int NIDX  = 1 << IB;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;

  localparam int B_PLAY = 0;
  localparam int B_STOP = 1;
  localparam int B_NEXT = 2;
  localparam int B_PREV = 3;

  // ---------------- clock / reset ----------------
  logic clk_10m  = 1'b0;
  logic reset    = 1'b0;
  logic btn_play = 1'b0;
  logic btn_stop = 1'b0;
  logic btn_next = 1'b0;
  logic btn_prev = 1'b0;
  logic loop_en  = 1'b0;
  logic [1:0] tempo = 2'b00;

  logic [AW-1:0] rom_addr;
  logic mute, playing, paused, beat_tick;
  logic [1:0] state_dbg;

  always #50 clk_10m = ~clk_10m;

  play_ctrl #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .SONG_BITS   (SB),
    .IDX_BITS    (IB),
    .CNT_BITS    (5)
  ) dut (
    .clk_10m   (clk_10m),
    .reset     (reset),
    .btn_play  (btn_play),
    .btn_stop  (btn_stop),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .loop_en   (loop_en),
    .tempo     (tempo),
    .rom_addr  (rom_addr),
    .mute      (mute),
    .playing   (playing),
    .paused    (paused),
    .beat_tick (beat_tick),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Player state in plain integers: which song, which note, how far into
  // the beat, and how long the current beat is.
  int m_st, m_song, m_idx, m_cnt, m_per;
  bit m_pp, m_ps, m_pn, m_pv;
  logic [AW-1:0] x_addr;
  logic x_mute, x_play, x_pause, x_tick;

  function automatic int beat_len(input logic [1:0] t);
    if (t == 2'b01) return BEAT / 2;
    if (t == 2'b10) return BEAT * 2;
    return BEAT;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_song = 0; m_idx = 0; m_cnt = 0; m_per = BEAT;
    m_pp = 0; m_ps = 0; m_pn = 0; m_pv = 0;
    x_addr = '0; x_mute = 1'b1; x_play = 1'b0; x_pause = 1'b0; x_tick = 1'b0;
  endtask

  task automatic model_step();
    bit up_play, up_stop, up_next, up_prev;
    up_play = btn_play && !m_pp;
    up_stop = btn_stop && !m_ps;
    up_next = btn_next && !m_pn;
    up_prev = btn_prev && !m_pv;
    // what the outputs will show after this edge: the player as it is now
    x_addr  = AW'(m_song * NIDX + m_idx);
    x_mute  = !(m_st == M_PLAY && (m_cnt + GAP < m_per));
    x_play  = (m_st == M_PLAY);
    x_pause = (m_st == M_PAUSE);
    x_tick  = (m_st == M_PLAY && m_cnt == m_per - 1);
    if (up_stop) begin
      m_st = M_IDLE; m_idx = 0; m_cnt = 0;
    end else if (up_next) begin
      m_song = (m_song + 1) % NSONG; m_idx = 0; m_cnt = 0;
    end else if (up_prev) begin
      m_song = (m_song + NSONG - 1) % NSONG; m_idx = 0; m_cnt = 0;
    end else if (up_play) begin
      if (m_st == M_IDLE) begin
        m_st = M_PLAY; m_idx = 0; m_cnt = 0; m_per = beat_len(tempo);
      end else if (m_st == M_PLAY) m_st = M_PAUSE;
      else m_st = M_PLAY;
    end else if (m_st == M_PLAY) begin
      if (m_cnt == m_per - 1) begin
        m_cnt = 0;
        m_per = beat_len(tempo);
        if (m_idx == NIDX - 1) begin
          m_idx = 0;
          if (!loop_en) m_st = M_IDLE;
        end else m_idx = m_idx + 1;
      end else m_cnt = m_cnt + 1;
    end
    m_pp = btn_play; m_ps = btn_stop; m_pn = btn_next; m_pv = btn_prev;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance the model with the inputs the DUT sees at this edge,
  // then compare all outputs just after the edge.
  task automatic cycle();
    if (!reset) model_reset(); else model_step();
    @(posedge clk_10m); #1;
    checks++;
    if ({rom_addr, mute, playing, paused, beat_tick} !== {x_addr, x_mute, x_play, x_pause, x_tick}) begin
      errors++;
      $display("FAIL model t=%0t got addr=%h mute=%b play=%b pause=%b tick=%b exp addr=%h mute=%b play=%b pause=%b tick=%b",
               $time, rom_addr, mute, playing, paused, beat_tick, x_addr, x_mute, x_play, x_pause, x_tick);
    end
  endtask

  task automatic press(input int which);
    case (which)
      B_PLAY:  btn_play = 1'b1;
      B_STOP:  btn_stop = 1'b1;
      B_NEXT:  btn_next = 1'b1;
      default: btn_prev = 1'b1;
    endcase
    cycle();
    btn_play = 1'b0; btn_stop = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_play = i[0]; btn_next = ~i[0]; btn_stop = i[1]; btn_prev = i[0];
      cycle();
      checks++;
      if ({rom_addr, mute, playing, beat_tick} !== {4'h0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold got addr=%h mute=%b play=%b tick=%b exp 0 1 0 0", rom_addr, mute, playing, beat_tick);
      end
    end
    btn_play = 0; btn_next = 0; btn_stop = 0; btn_prev = 0;
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if ({rom_addr, mute, playing, paused} !== {4'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle got addr=%h mute=%b play=%b pause=%b exp 0 1 0 0", rom_addr, mute, playing, paused);
    end
  endtask

  task automatic test_play_through();
    int ticks, last, quiet0;
    logic [AW-1:0] seen [4];
    ticks = 0; last = -1; quiet0 = 0;
    loop_en = 1'b0; tempo = 2'b00;
    press(B_PLAY);
    for (int n = 1; n <= 40; n++) begin
      cycle();
      if (!mute) quiet0++;
      if (beat_tick) begin
        checks++;
        if ((last < 0 && n != 8) || (last >= 0 && n - last != 8)) begin
          errors++;
          $display("FAIL tick_spacing got n=%0d last=%0d exp spacing 8", n, last);
        end
        if (ticks < 4) seen[ticks] = rom_addr;
        last = n; ticks++;
      end
    end
    checks++;
    if (ticks != 4) begin errors++; $display("FAIL tick_count got %0d exp 4", ticks); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < ticks && seen[k] !== AW'(k)) begin
        errors++; $display("FAIL addr_seq beat %0d got %h exp %h", k, seen[k], AW'(k));
      end
    end
    checks++;
    if (quiet0 != 24) begin errors++; $display("FAIL sound_cycles got %0d exp 24", quiet0); end
    checks++;
    if ({rom_addr, mute, playing} !== {4'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL end_idle got addr=%h mute=%b play=%b exp 0 1 0", rom_addr, mute, playing);
    end
  endtask

  task automatic test_loop_tempo();
    int n, nt;
    int t [6];
    logic [AW-1:0] a5;
    nt = 0; a5 = '1;
    loop_en = 1'b1; tempo = 2'b00;
    press(B_PLAY);
    n = 0;
    while (n < 3) begin cycle(); n++; end
    tempo = 2'b01;
    while (n < 26) begin
      cycle(); n++;
      if (beat_tick && nt < 6) begin
        t[nt] = n;
        if (nt == 4) a5 = rom_addr;
        nt++;
      end
    end
    checks++;
    if (nt != 5) begin errors++; $display("FAIL loop_ticks got %0d exp 5", nt); end
    else begin
      checks++;
      if (t[0] != 8) begin errors++; $display("FAIL first_beat got %0d exp 8", t[0]); end
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (t[k] - t[k-1] != 4) begin
          errors++; $display("FAIL fast_beat %0d got %0d exp 4", k, t[k] - t[k-1]);
        end
      end
      checks++;
      if (a5 !== 4'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", a5); end
    end
    checks++;
    if (playing !== 1'b1) begin errors++; $display("FAIL loop_playing got %b exp 1", playing); end
    loop_en = 1'b0; tempo = 2'b00;
    press(B_STOP);
  endtask

  task automatic test_pause_resume();
    int n;
    loop_en = 1'b0; tempo = 2'b00;
    press(B_PLAY);
    n = 0;
    while (!(m_idx == 2 && m_cnt == 5) && n < 40) begin cycle(); n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL pause_reach got timeout exp idx2 cnt5"); end
    press(B_PLAY);
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if ({rom_addr, mute, paused, beat_tick} !== {4'h2, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL paused_hold got addr=%h mute=%b pause=%b tick=%b exp 2 1 1 0", rom_addr, mute, paused, beat_tick);
      end
    end
    press(B_PLAY);
    n = 0;
    do begin cycle(); n++; end while (!beat_tick && n < 12);
    checks++;
    if (n != 3) begin errors++; $display("FAIL resume_tick got %0d exp 3", n); end
    press(B_STOP);
  endtask

  task automatic test_song_select();
    press(B_PREV);
    cycle();
    checks++;
    if (rom_addr !== 4'hC) begin errors++; $display("FAIL prev_wrap got %h exp c", rom_addr); end
    press(B_PLAY);
    cycle();
    btn_next = 1'b1; btn_stop = 1'b1;
    cycle();
    btn_next = 1'b0; btn_stop = 1'b0;
    cycle(); cycle();
    checks++;
    if ({rom_addr, playing} !== {4'hC, 1'b0}) begin
      errors++; $display("FAIL stop_over_next got addr=%h play=%b exp c 0", rom_addr, playing);
    end
    btn_next = 1'b1; btn_prev = 1'b1;
    cycle();
    btn_next = 1'b0; btn_prev = 1'b0;
    cycle();
    checks++;
    if (rom_addr !== 4'h0) begin errors++; $display("FAIL next_over_prev got %h exp 0", rom_addr); end
    btn_next = 1'b1;
    for (int i = 0; i < 50; i++) cycle();
    btn_next = 1'b0;
    cycle();
    checks++;
    if (rom_addr !== 4'h4) begin errors++; $display("FAIL held_next got %h exp 4", rom_addr); end
  endtask

  task automatic test_async_reset();
    int n;
    press(B_PLAY);
    n = 0;
    while (m_idx != 2 && n < 40) begin cycle(); n++; end
    cycle();
    checks++;
    if ({rom_addr, playing} !== {4'h6, 1'b1}) begin
      errors++; $display("FAIL pre_reset got addr=%h play=%b exp 6 1", rom_addr, playing);
    end
    @(negedge clk_10m);
    reset = 1'b0;
    #1;
    checks++;
    if ({rom_addr, mute, playing, paused, beat_tick} !== {4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got addr=%h mute=%b play=%b pause=%b tick=%b exp 0 1 0 0 0",
               rom_addr, mute, playing, paused, beat_tick);
    end
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      btn_play = ($urandom_range(0, 11) == 0);
      btn_stop = ($urandom_range(0, 59) == 0);
      btn_next = ($urandom_range(0, 39) == 0);
      btn_prev = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) tempo = 2'($urandom_range(0, 3));
      cycle();
    end
    btn_play = 0; btn_stop = 0; btn_next = 0; btn_prev = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_play_through();
    test_loop_tempo();
    test_pause_resume();
    test_song_select();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/play_ctrl.md
Name: play_ctrl

Overview:
Playback sequencer for the tone player. Runs on the 10 MHz system clock and replaces the free-running 4 Hz address counter. Drives the song ROM address as {song, note index} and gates the speaker through `mute`. Supports play/pause, stop, next/prev song (wrapping), loop mode, a tempo select, and an articulation gap at the end of each beat.

Parameters:
BEAT_CYCLES, 2500000, clk_10m cycles per beat at normal tempo (4 Hz)
GAP_CYCLES, 250000, cycles at the end of each beat with mute forced to 1
SONG_BITS, 2, song select width (NUM_SONGS = 2**SONG_BITS)
IDX_BITS, 6, note index width; a song is 2**IDX_BITS notes
CNT_BITS, 23, beat counter width; must hold 2*BEAT_CYCLES-1

Ports:
clk_10m  in  1  system clock, 10 MHz
reset  in  1  asynchronous, active-low reset (0 = reset)
btn_play  in  1  play/pause toggle; level, synchronous to clk_10m, debounced upstream
btn_stop  in  1  stop; level, synchronous
btn_next  in  1  next song; level, synchronous
btn_prev  in  1  previous song; level, synchronous
loop_en  in  1  1 = restart the song at its end; 0 = stop at its end
tempo  in  2  00 normal, 01 fast (BEAT/2), 10 slow (2*BEAT), 11 normal
rom_addr  out  SONG_BITS+IDX_BITS  {song, idx} to song_rom
mute  out  1  1 = divider output silenced
playing  out  1  state == PLAY
paused  out  1  state == PAUSE
beat_tick  out  1  one-cycle pulse when idx advances

Behaviour:
- All flops reset asynchronously when reset = 0. Reset values:
  - state = IDLE, song = 0, idx = 0, beat_cnt = 0, period = BEAT_CYCLES
  - edge-detect registers = 0
  - rom_addr = 0, mute = 1, playing = 0, paused = 0, beat_tick = 0
- Every button is rising-edge detected using a previous-value register. A held button acts once only.
- Edge priority in a single cycle: stop > next > prev > play. Only the highest-priority edge acts; lower-priority edges in that cycle are discarded.
- State machine (IDLE, PLAY, PAUSE):
  - stop edge, any state -> IDLE; idx = 0, beat_cnt = 0; song kept.
  - next edge -> song = song+1 mod NUM_SONGS; idx = 0, beat_cnt = 0; state unchanged.
  - prev edge -> song = song-1 mod NUM_SONGS (0 wraps to NUM_SONGS-1); idx = 0, beat_cnt = 0; state unchanged.
  - play edge:
    - IDLE -> PLAY with idx = 0, beat_cnt = 0.
    - PLAY -> PAUSE; beat_cnt and idx are frozen.
    - PAUSE -> PLAY; resumes from the frozen beat_cnt and idx.
- Beat timing:
  - In PLAY, beat_cnt increments by 1 every cycle. In IDLE and PAUSE it holds.
  - When beat_cnt == period-1 in PLAY:
    - beat_cnt <= 0 and beat_tick = 1 for that single cycle.
    - If idx == 2**IDX_BITS-1: with loop_en = 1, idx <= 0 and the state stays PLAY; with loop_en = 0, idx <= 0 and state <= IDLE.
    - Otherwise idx <= idx+1.
  - period is reloaded from tempo only at a beat boundary and on every IDLE->PLAY transition. A tempo change mid-beat does not shorten or stretch the current beat.
  - A button edge on the same cycle as a beat boundary overrides the boundary update. beat_tick still pulses on that cycle.
- Outputs are registered, with one cycle of latency from the state/idx update:
  - rom_addr = {song, idx}
  - mute = !(state == PLAY && beat_cnt < period - GAP_CYCLES)
  - playing and paused decode the state.
- GAP_CYCLES >= period is legal. mute then stays 1 for the whole beat.

Decomposition:
- Package `play_ctrl_pkg`:
  - state enum: IDLE = 2'b00, PLAY = 2'b01, PAUSE = 2'b10
  - tempo codes: TEMPO_NORM = 2'b00, TEMPO_FAST = 2'b01, TEMPO_SLOW = 2'b10
  - function mapping a tempo code to a period
- Sub-module `beat_timer`: beat_cnt, period latch, boundary detect, gap compare.
- Top level: FSM, edge detect, song/idx registers, output registers.

Test Plan:
- Bench parameters: BEAT_CYCLES = 8, GAP_CYCLES = 2, IDX_BITS = 2.
- Reset check: hold reset = 0 with buttons toggling -> rom_addr = 0, mute = 1, playing = 0, beat_tick = 0. Release reset, wait 20 cycles with no input -> still IDLE.
- Play through, loop_en = 0: one play pulse on song 0 ->
  - beat_tick every 8 cycles; rom_addr goes 0, 1, 2, 3.
  - mute is 0 for 6 cycles and 1 for 2 cycles in each beat.
  - After the 4th tick: IDLE, rom_addr = 0, mute = 1.
- Loop and tempo: loop_en = 1; set tempo = 01 at beat_cnt = 3 ->
  - The current beat still lasts 8 cycles; the next beats last 4 cycles.
  - idx wraps 3 -> 0 and playing stays 1.
- Pause/resume: pause at idx = 2, beat_cnt = 5; hold 30 cycles ->
  - rom_addr holds 2, mute = 1, paused = 1, no beat_tick.
  - After resume, the next tick arrives 3 cycles later.
- Song select and priority:
  - prev from song 0 -> song 3, rom_addr = 8'hC0 at default widths (4'hC with IDX_BITS = 2).
  - next and stop in the same cycle -> IDLE, song unchanged.
  - next and prev in the same cycle -> song+1.
  - Button held 50 cycles -> a single song step.
- Async reset mid-play: drop reset between clock edges at idx = 2 -> outputs reach reset values immediately, without waiting for a clock edge.
